// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game sequencer and the ball/paddle/pixel logic.
// "slave" is the sequencer side; "master" is the surrounding datapath side.
interface pong_game_ctrl_if #(
    parameter int SCORE_W = 8
);
    logic               refr_tick;
    logic               start_k;
    logic               ball_hit;
    logic               ball_miss;
    logic               paddle_en;
    logic               ball_en;
    logic               ball_reset;
    logic [2:0]         lives;
    logic [SCORE_W-1:0] score;
    logic               game_over;
    logic [2:0]         state;

    modport master (
        output refr_tick, start_k, ball_hit, ball_miss,
        input  paddle_en, ball_en, ball_reset, lives, score, game_over, state
    );

    modport slave (
        input  refr_tick, start_k, ball_hit, ball_miss,
        output paddle_en, ball_en, ball_reset, lives, score, game_over, state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve hold, rally gating, score and lives bookkeeping.
// Advances on the per-frame refresh tick; start button is synchronized here.
module pong_game_ctrl #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 120,
    parameter int SCORE_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    pong_game_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        MISS  = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [2:0]         sync_q;
    logic               start_pe;

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] holds the previous level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], bus.start_k};
        end
    end

    assign start_pe = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            lives_q     <= 3'(LIVES);
            score_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        score_d     = score_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_pe) begin
                    lives_d     = 3'(LIVES);
                    score_d     = '0;
                    frame_cnt_d = '0;
                    state_d     = SERVE;
                end
            end

            SERVE: begin
                if (bus.refr_tick) begin
                    if (frame_cnt_q == 8'(SERVE_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        state_d     = PLAY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end

            PLAY: begin
                // a miss in the same cycle as a hit discards the hit
                if (bus.ball_miss) begin
                    state_d = MISS;
                end else if (bus.ball_hit && (score_q != '1)) begin
                    score_d = score_q + 1'b1;
                end
            end

            MISS: begin
                frame_cnt_d = '0;
                if (lives_q > 3'd1) begin
                    lives_d = lives_q - 3'd1;
                    state_d = SERVE;
                end else begin
                    lives_d = '0;
                    state_d = OVER;
                end
            end

            OVER: begin
                if (start_pe && (frame_cnt_q >= 8'(OVER_FRAMES))) begin
                    lives_d     = 3'(LIVES);
                    score_d     = '0;
                    frame_cnt_d = '0;
                    state_d     = SERVE;
                end else if (bus.refr_tick && (frame_cnt_q < 8'(OVER_FRAMES))) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.state      = state_q;
    assign bus.lives      = lives_q;
    assign bus.score      = score_q;
    assign bus.paddle_en  = (state_q == SERVE) || (state_q == PLAY);
    assign bus.ball_en    = (state_q == PLAY);
    assign bus.ball_reset = (state_q != PLAY);
    assign bus.game_over  = (state_q == OVER);
endmodule
